// File: rtl/entity_pixel_renderer.sv
// entity_pixel_renderer: two-stage pixel colour pipeline
// with sprite ROM fetch, animation timing and death FSM.
module entity_pixel_renderer #(
  parameter int ANIM_FRAMES  = 8,
  parameter int DEATH_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [6:0]  entity_code,
  input  logic [9:0]  entityX,
  input  logic [9:0]  entityY,
  input  logic [1:0]  entityDir,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        lose_game,
  input  logic        frame_start,
  input  logic        restart,
  output logic [11:0] sprite_addr,
  input  logic        sprite_data,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        dying,
  output logic        game_over
);

  localparam int FCW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int DCW = (DEATH_FRAMES > 8) ? $clog2(DEATH_FRAMES) : 3;

  localparam logic [2:0] C_BG     = 3'd0;
  localparam logic [2:0] C_PAC    = 3'd1;
  localparam logic [2:0] C_MAZE   = 3'd2;
  localparam logic [2:0] C_BLINKY = 3'd3;
  localparam logic [2:0] C_PINKY  = 3'd4;
  localparam logic [2:0] C_INKY   = 3'd5;
  localparam logic [2:0] C_CLYDE  = 3'd6;
  localparam logic [2:0] C_PELLET = 3'd7;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    DYING = 2'd1,
    OVER  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [DCW-1:0]   death_cnt_q, death_cnt_d;
  logic             anim_q, anim_d;
  logic             dying_q, dying_d;
  logic             game_over_q, game_over_d;

  logic [2:0]       code0_d, code1_q;
  logic             inbox_d, inbox1_q;
  logic [11:0]      addr_d, addr_q;
  logic [9:0]       rel_x, rel_y;
  logic [3:0]       sprite_id;
  logic [23:0]      rgb_d, rgb_q;
  logic             pix_on;

  // Stage 0: sprite-relative offset, bounding box and ROM address
  always_comb begin
    code0_d   = (entity_code > 7'd7) ? C_BG : entity_code[2:0];
    rel_x     = DrawX - entityX;
    rel_y     = DrawY - entityY;
    inbox_d   = (rel_x < 10'd16) && (rel_y < 10'd16);
    sprite_id = 4'd0;
    unique case (1'b1)
      (code0_d == C_PAC):
        sprite_id = {1'b0, entityDir, anim_q};
      (code0_d >= C_BLINKY && code0_d <= C_CLYDE):
        sprite_id = {3'b100, anim_q};
      default:
        sprite_id = 4'd0;
    endcase
    addr_d = {sprite_id, rel_y[3:0], rel_x[3:0]};
  end

  // Stage 1: colour lookup gated by ROM bit and game state
  always_comb begin
    rgb_d  = 24'h000000;
    pix_on = inbox1_q && sprite_data;
    case (code1_q)
      C_MAZE:   rgb_d = 24'h0000FF;
      C_PELLET: rgb_d = 24'hFFB8AE;
      C_PAC: begin
        if (state_q == PLAY && pix_on)
          rgb_d = 24'hFFFF00;
        else if (state_q == DYING && pix_on && !death_cnt_q[2])
          rgb_d = 24'hFFFF00;
      end
      C_BLINKY: if (state_q == PLAY && pix_on) rgb_d = 24'hFF0000;
      C_PINKY:  if (state_q == PLAY && pix_on) rgb_d = 24'hFFB8FF;
      C_INKY:   if (state_q == PLAY && pix_on) rgb_d = 24'h00FFFF;
      C_CLYDE:  if (state_q == PLAY && pix_on) rgb_d = 24'hFFB852;
      default:  rgb_d = 24'h000000;
    endcase
  end

  // Game FSM next state, animation and death counters
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    death_cnt_d = death_cnt_q;
    anim_d      = anim_q;
    if (restart) begin
      state_d     = PLAY;
      frame_cnt_d = '0;
      death_cnt_d = '0;
      anim_d      = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (frame_start) begin
            if (frame_cnt_q == FCW'(ANIM_FRAMES - 1)) begin
              frame_cnt_d = '0;
              anim_d      = ~anim_q;
            end else begin
              frame_cnt_d = frame_cnt_q + FCW'(1);
            end
          end
          if (lose_game) begin
            state_d     = DYING;
            death_cnt_d = '0;
          end
        end
        DYING: begin
          if (frame_start) begin
            if (death_cnt_q == DCW'(DEATH_FRAMES - 1))
              state_d = OVER;
            else
              death_cnt_d = death_cnt_q + DCW'(1);
          end
        end
        OVER: state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
    dying_d     = (state_d == DYING);
    game_over_d = (state_d == OVER);
  end

  // Pipeline, FSM and status registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q      <= '0;
      code1_q     <= C_BG;
      inbox1_q    <= 1'b0;
      rgb_q       <= '0;
      state_q     <= PLAY;
      frame_cnt_q <= '0;
      death_cnt_q <= '0;
      anim_q      <= 1'b0;
      dying_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      code1_q     <= code0_d;
      inbox1_q    <= inbox_d;
      rgb_q       <= rgb_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      death_cnt_q <= death_cnt_d;
      anim_q      <= anim_d;
      dying_q     <= dying_d;
      game_over_q <= game_over_d;
    end
  end

  assign sprite_addr = addr_q;
  assign Red         = rgb_q[23:16];
  assign Green       = rgb_q[15:8];
  assign Blue        = rgb_q[7:0];
  assign dying       = dying_q;
  assign game_over   = game_over_q;

endmodule

// File: doc/entity_pixel_renderer.md
# entity_pixel_renderer

Turns the per-pixel entity code and entity coordinates from the entity selector into VGA colour. It sits between the selector and the VGA colour outputs, and fetches sprite bits from an external synchronous sprite ROM. It also owns sprite animation timing and the death/game-over state machine, which is driven by the selector's `lose_game` flag.

## Interface
Parameters:
- ANIM_FRAMES, 8: `frame_start` pulses per animation-phase toggle.
- DEATH_FRAMES, 60: `frame_start` pulses spent in DYING.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- entity_code  in  7  selector code: 0 bg, 1 pacman, 2 maze, 3 blinky, 4 pinky, 5 inky, 6 clyde, 7 pellet; >7 treated as 0
- entityX, entityY  in  10 each  top-left corner of the selected sprite
- entityDir  in  2  pacman direction
- DrawX, DrawY  in  10 each  current pixel
- lose_game  in  1  pacman/ghost overlap on the current pixel
- frame_start  in  1  one-cycle pulse, once per frame
- restart  in  1  one-cycle pulse, returns to PLAY
- sprite_addr  out  12  ROM address {id[3:0], row[3:0], col[3:0]}
- sprite_data  in  1  ROM pixel bit, valid 1 cycle after sprite_addr
- Red, Green, Blue  out  8 each  pixel colour
- dying  out  1  high in DYING
- game_over  out  1  high in OVER

## Operation
- **Stage 0 (registered):**
  - rel_x = DrawX − entityX and rel_y = DrawY − entityY, both 10-bit modulo.
  - inbox = (rel_x < 16) && (rel_y < 16), unsigned, so negative offsets wrap to large values and fall outside.
  - sprite_addr = {id, rel_y[3:0], rel_x[3:0]}.
  - The code and inbox are carried into stage 1.
- **Sprite id:**
  - Pacman = {0, entityDir, anim}.
  - Ghosts (3–6) = {100, anim}.
  - All other codes drive id 0; their ROM data is ignored.
- **Stage 1 (registered RGB):**
  - bg → 000000.
  - maze → 0000FF.
  - pellet → FFB8AE.
  - Sprite codes with inbox && sprite_data → pacman FFFF00, blinky FF0000, pinky FFB8FF, inky 00FFFF, clyde FFB852.
  - Sprite codes otherwise → 000000.
- **Animation:**
  - frame_cnt counts `frame_start` pulses from 0 to ANIM_FRAMES−1.
  - On wrap, anim toggles.
  - Runs only in PLAY; held in DYING and OVER.
- **FSM (state register, reset → PLAY):**
  - PLAY: lose_game=1 → DYING, death_cnt←0.
  - DYING:
    - Each `frame_start` increments death_cnt.
    - When death_cnt reaches DEATH_FRAMES−1 and a `frame_start` arrives → OVER.
    - Ghost pixels render 000000.
    - Pacman pixels render 000000 when death_cnt[2]=1 (flash); otherwise normal.
  - OVER: only maze and pellet render; every other code gives 000000.
  - restart=1 in any state → PLAY next cycle, clearing frame_cnt, death_cnt and anim.
  - restart has priority over a simultaneous lose_game.
  - lose_game is ignored outside PLAY.
- **Status outputs:**
  - dying = (state==DYING).
  - game_over = (state==OVER).
  - Both are registered from the state.
- **Reset values:**
  - Red/Green/Blue 0, sprite_addr 0, dying 0, game_over 0.
  - State PLAY, counters 0, anim 0.
  - Pipeline code registers 0 (bg).

## Timing
- Pixel latency: inputs on cycle N → sprite_addr on N+1 → RGB on N+2. The pipeline is fully pipelined, one pixel per clock, with no stalls.
- The ROM must return sprite_data in the cycle after sprite_addr changes. Stage 1 samples it together with the stage-0 registers.
- FSM state applied to colour is the state at the stage-1 clock edge.
- The state change is visible on dying/game_over one cycle after the triggering lose_game or `frame_start` edge.
- Reset asserted mid-frame immediately clears all outputs asynchronously. Output is valid again two clocks after deassertion.
- frame_start and restart in the same cycle: restart wins; the pulse is not counted.

## Test plan
- Reset, then entity_code=2 at cycle 0 → RGB=0000FF at cycle 2. Code=7 → FFB8AE. Code=9 → 000000.
- Pacman: entityX=100, entityY=50, DrawX=105, DrawY=53, dir=2, anim=0 → sprite_addr=0x435 one cycle later. With sprite_data=1, RGB=FFFF00 one cycle after that. DrawX=99 (rel_x wraps to 1023) → 000000.
- Blinky with sprite_data=1 → FF0000 and id=8. After 8 frame_start pulses → id=9.
- lose_game pulse in PLAY → dying=1 next cycle. Ghost pixel → 000000. Pacman pixel with death_cnt=4 → 000000. After 60 frame_start pulses → game_over=1, and pellet still renders FFB8AE.
- In OVER, restart with lose_game=1 in the same cycle → PLAY with dying=0 and game_over=0, anim=0.
- Assert Reset during DYING with Red=FF → all outputs 0 immediately; state PLAY after release.
